// File: rtl/program_loader.sv
// Bit-serial program loader: receives framed 16-bit words (start, MSB-first data, stop),
// treats the first as a word count and writes the following words to memory from address 0.
module program_loader #(
    parameter int CLKS_PER_BIT = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int MEM_DEPTH    = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  serialIn,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [15:0]           memWriteData,
    output logic                  cpuHold,
    output logic                  loadDone,
    output logic                  loadError
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [31:0]   DEPTH  = 32'(MEM_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [4:0]            bitcnt_q, bitcnt_d;
    logic [15:0]           shift_q, shift_d;
    logic                  hdr_q, hdr_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  sync1_q, sync2_q;
    logic                  rx_s;
    logic                  expire_s;

    assign rx_s     = sync2_q;
    assign expire_s = (timer_q == T_ONE);

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serialIn;
            sync2_q <= sync1_q;
        end
    end

    // Frame receiver, header handling and memory write sequencing.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        hdr_d       = hdr_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = 1'b0;
        hold_d      = hold_q;
        done_d      = done_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    timer_d = T_HALF;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (expire_s) begin
                    if (!rx_s) begin
                        state_d  = S_DATA;
                        timer_d  = T_FULL;
                        bitcnt_d = 5'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_DATA: begin
                if (expire_s) begin
                    shift_d  = {shift_q[14:0], rx_s};
                    timer_d  = T_FULL;
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd15) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_STOP: begin
                if (expire_s) begin
                    if (!rx_s) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (!hdr_q) begin
                        if (shift_q == 16'd0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
                        end else if ({16'd0, shift_q} > DEPTH) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            state_d     = S_IDLE;
                            remaining_d = shift_q;
                            hdr_d       = 1'b1;
                        end
                    end else begin
                        state_d = S_WRITE;
                        wr_d    = 1'b1;
                        wdata_d = shift_q;
                    end
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_WRITE: begin
                remaining_d = remaining_q - 16'd1;
                // The final address is kept rather than stepped past MEM_DEPTH-1.
                if (remaining_q == 16'd1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
                err_d   = 1'b1;
                done_d  = 1'b0;
                hold_d  = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bitcnt_q    <= 5'd0;
            shift_q     <= 16'd0;
            hdr_q       <= 1'b0;
            remaining_q <= 16'd0;
            addr_q      <= '0;
            wdata_q     <= 16'd0;
            wr_q        <= 1'b0;
            hold_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            hdr_q       <= hdr_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign memWrite     = wr_q;
    assign memAddress   = addr_q;
    assign memWriteData = wdata_q;
    assign cpuHold      = hold_q;
    assign loadDone     = done_q;
    assign loadError    = err_q;

endmodule
